// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI burst encoding, line geometry,
// the fixed miss-burst shape and the dispatch FSM state type.
package cc_pkg;

    // AXI AR burst type used for critical-word-first line fills
    localparam logic [1:0] BURST_WRAP = 2'b10;

    // Line geometry: 64-byte line, 6 offset bits, filled as 8 x 8-byte beats
    localparam int CC_LINE_W   = 512;
    localparam int CC_OFFSET_W = 6;
    localparam int CC_BEATS    = 8;

    // Low address bits that select a byte within one 8-byte beat
    localparam int CC_BEAT_LSB = 3;

    // Miss burst shape: 8 beats of 8 bytes each
    localparam logic [3:0] CC_ARLEN  = 4'(CC_BEATS - 1);
    localparam logic [2:0] CC_ARSIZE = 3'd3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        AR_WAIT = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_hit_dispatch_unit_chk.sv
// Protocol checker for cc_hit_dispatch_unit: a completed R burst must always
// retire a miss that is actually outstanding.
module cc_hit_dispatch_unit_chk (
    input logic clk,
    input logic rst_n,
    input logic rdone,
    input logic outs_zero
);

    // Catch an rlast handshake arriving while the outstanding count is zero
    always @(posedge clk) begin
        if (rst_n && rdone) begin
            assert (!outs_zero)
                else $error("cc_hit_dispatch_unit: rlast handshake with no outstanding miss");
        end
    end

endmodule

bind cc_hit_dispatch_unit cc_hit_dispatch_unit_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdone     (rdone_s),
    .outs_zero (outs_zero_s)
);

// File: rtl/cc_hit_dispatch_unit.sv
// Hit/miss dispatch: accepts tag-compare results in order, writes the hit
// flag (and, on a hit, the line+offset word) to the reorder FIFOs in the
// accept cycle, and launches a WRAP line fill on the AR channel for a miss.
module cc_hit_dispatch_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            lookup_valid_i,
    input  logic                            lookup_hit_i,
    input  logic [ADDR_WIDTH-1:0]           lookup_addr_i,
    input  logic [CC_LINE_W-1:0]            lookup_line_i,
    output logic                            lookup_ready_o,
    input  logic                            hit_flag_fifo_afull_i,
    output logic                            hit_flag_fifo_wren_o,
    output logic                            hit_flag_fifo_wdata_o,
    input  logic                            hit_data_fifo_afull_i,
    output logic                            hit_data_fifo_wren_o,
    output logic [CC_OFFSET_W+CC_LINE_W-1:0] hit_data_fifo_wdata_o,
    output logic [ADDR_WIDTH-1:0]           mem_araddr_o,
    output logic [3:0]                      mem_arlen_o,
    output logic [2:0]                      mem_arsize_o,
    output logic [1:0]                      mem_arburst_o,
    output logic                            mem_arvalid_o,
    input  logic                            mem_arready_i,
    input  logic                            mem_rvalid_i,
    input  logic                            mem_rready_i,
    input  logic                            mem_rlast_i
);

    localparam int              OUTS_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTSTANDING);

    cc_state_e               state_r;
    cc_state_e               state_s;
    logic [OUTS_W-1:0]       outs_r;
    logic [ADDR_WIDTH-1:0]   araddr_r;
    logic                    ready_s;
    logic                    hit_acc_s;
    logic                    miss_acc_s;
    logic                    rdone_s;
    logic                    outs_zero_s;

    assign hit_acc_s   = lookup_valid_i & ready_s & lookup_hit_i;
    assign miss_acc_s  = lookup_valid_i & ready_s & ~lookup_hit_i;
    assign rdone_s     = mem_rvalid_i & mem_rready_i & mem_rlast_i;
    assign outs_zero_s = (outs_r == {OUTS_W{1'b0}});

    assign lookup_ready_o = ready_s;
    assign mem_arvalid_o  = (state_r == AR_WAIT);
    assign mem_araddr_o   = araddr_r;
    assign mem_arlen_o    = CC_ARLEN;
    assign mem_arsize_o   = CC_ARSIZE;
    assign mem_arburst_o  = BURST_WRAP;

    // Ready: idle, flag FIFO has room, and the path this lookup needs has room
    always_comb begin
        ready_s = 1'b0;
        if (!rst_n) begin
            ready_s = 1'b0;
        end else if ((state_r == IDLE) && !hit_flag_fifo_afull_i) begin
            if (lookup_hit_i) begin
                ready_s = ~hit_data_fifo_afull_i;
            end else begin
                ready_s = (outs_r < OUTS_MAX);
            end
        end else begin
            ready_s = 1'b0;
        end
    end

    // FIFO writes happen only in the accept cycle; data rides with a hit flag
    always_comb begin
        hit_flag_fifo_wren_o  = 1'b0;
        hit_flag_fifo_wdata_o = 1'b0;
        hit_data_fifo_wren_o  = 1'b0;
        hit_data_fifo_wdata_o = '0;
        if (hit_acc_s) begin
            hit_flag_fifo_wren_o  = 1'b1;
            hit_flag_fifo_wdata_o = 1'b1;
            hit_data_fifo_wren_o  = 1'b1;
            hit_data_fifo_wdata_o = {lookup_addr_i[CC_OFFSET_W-1:0], lookup_line_i};
        end else if (miss_acc_s) begin
            hit_flag_fifo_wren_o  = 1'b1;
            hit_flag_fifo_wdata_o = 1'b0;
        end else begin
            hit_flag_fifo_wren_o  = 1'b0;
        end
    end

    // Next state: a miss parks us in AR_WAIT until the AR handshake
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_acc_s) begin
                    state_s = AR_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            AR_WAIT: begin
                if (mem_arready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = AR_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // AR address: beat-aligned miss address captured at accept, held until handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_r <= '0;
        end else if (miss_acc_s) begin
            araddr_r <= {lookup_addr_i[ADDR_WIDTH-1:CC_BEAT_LSB], {CC_BEAT_LSB{1'b0}}};
        end
    end

    // Outstanding misses: +1 per miss accept, -1 per completed R burst, floor at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs_r <= '0;
        end else begin
            case ({miss_acc_s, rdone_s})
                2'b10:   outs_r <= outs_r + {{(OUTS_W-1){1'b0}}, 1'b1};
                2'b01:   outs_r <= outs_zero_s ? outs_r : outs_r - {{(OUTS_W-1){1'b0}}, 1'b1};
                default: outs_r <= outs_r;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_hit_dispatch_unit.sv
// Scoreboard bench for cc_hit_dispatch_unit: stimulus pushes expected FIFO
// writes and AR requests into queues; a negedge monitor pops and compares.
module tb_cc_hit_dispatch_unit;
    import cc_pkg::*;

    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           lookup_valid = 1'b0;
    logic           lookup_hit = 1'b0;
    logic [AW-1:0]  lookup_addr = '0;
    logic [511:0]   lookup_line = '0;
    logic           lookup_ready_o;
    logic           flag_afull = 1'b0;
    logic           hit_flag_fifo_wren_o;
    logic           hit_flag_fifo_wdata_o;
    logic           data_afull = 1'b0;
    logic           hit_data_fifo_wren_o;
    logic [517:0]   hit_data_fifo_wdata_o;
    logic [AW-1:0]  mem_araddr_o;
    logic [3:0]     mem_arlen_o;
    logic [2:0]     mem_arsize_o;
    logic [1:0]     mem_arburst_o;
    logic           mem_arvalid_o;
    logic           arready = 1'b0;
    logic           rvalid = 1'b0;
    logic           rready = 1'b0;
    logic           rlast = 1'b0;

    cc_hit_dispatch_unit #(.MAX_OUTSTANDING(4), .ADDR_WIDTH(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .lookup_valid_i        (lookup_valid),
        .lookup_hit_i          (lookup_hit),
        .lookup_addr_i         (lookup_addr),
        .lookup_line_i         (lookup_line),
        .lookup_ready_o        (lookup_ready_o),
        .hit_flag_fifo_afull_i (flag_afull),
        .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
        .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
        .hit_data_fifo_afull_i (data_afull),
        .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
        .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
        .mem_araddr_o          (mem_araddr_o),
        .mem_arlen_o           (mem_arlen_o),
        .mem_arsize_o          (mem_arsize_o),
        .mem_arburst_o         (mem_arburst_o),
        .mem_arvalid_o         (mem_arvalid_o),
        .mem_arready_i         (arready),
        .mem_rvalid_i          (rvalid),
        .mem_rready_i          (rready),
        .mem_rlast_i           (rlast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int outs_m   = 0;

    logic          exp_flag_q[$];
    logic [517:0]  exp_data_q[$];
    logic [AW-1:0] exp_ar_q[$];

    task automatic check(input string name, input logic [517:0] act, input logic [517:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] seed);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = seed + 32'(i);
        return l;
    endfunction

    // Monitor: every FIFO write and AR handshake must match the next expectation
    always @(negedge clk) begin
        if (hit_flag_fifo_wren_o) begin
            if (exp_flag_q.size() == 0) begin
                fail_now("flag_unexpected");
            end else begin
                logic e;
                e = exp_flag_q.pop_front();
                check("flag_wdata", 518'(hit_flag_fifo_wdata_o), 518'(e));
                check("data_wren_pair", 518'(hit_data_fifo_wren_o), 518'(e));
            end
        end else if (hit_data_fifo_wren_o) begin
            fail_now("data_without_flag");
        end
        if (hit_data_fifo_wren_o) begin
            if (exp_data_q.size() == 0) fail_now("data_unexpected");
            else check("data_wdata", hit_data_fifo_wdata_o, exp_data_q.pop_front());
        end
        if (mem_arvalid_o && arready) begin
            if (exp_ar_q.size() == 0) begin
                fail_now("ar_unexpected");
            end else begin
                check("ar_addr", 518'(mem_araddr_o), 518'(exp_ar_q.pop_front()));
                check("ar_len_size_burst", 518'({mem_arlen_o, mem_arsize_o, mem_arburst_o}),
                      518'({4'd7, 3'b011, 2'b10}));
            end
        end
    end

    task automatic push_hit(input logic [AW-1:0] a, input logic [511:0] l);
        exp_flag_q.push_back(1'b1);
        exp_data_q.push_back({a[5:0], l});
    endtask

    task automatic push_miss(input logic [AW-1:0] a);
        exp_flag_q.push_back(1'b0);
        exp_ar_q.push_back({a[AW-1:3], 3'b000});
    endtask

    // Hold a lookup until accepted (bounded), then withdraw it
    task automatic present(input logic h, input logic [AW-1:0] a, input logic [511:0] l);
        bit done = 1'b0;
        lookup_valid = 1'b1;
        lookup_hit   = h;
        lookup_addr  = a;
        lookup_line  = l;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (lookup_ready_o) done = 1'b1;
        end
        if (done) begin
            @(posedge clk); #1;
        end else begin
            n_checks++;
            $display("FAIL accept_timeout: got ready=0 for 40 cycles, expected accept (addr %0h)", a);
        end
        lookup_valid = 1'b0;
        lookup_hit   = 1'b0;
    endtask

    // Hold arready low for wait_cycles, then handshake; afterwards check ready vs model outs
    task automatic ar_finish(input logic [AW-1:0] a, input int wait_cycles);
        logic [AW-1:0] ea;
        ea = {a[AW-1:3], 3'b000};
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            check("arvalid_wait", 518'(mem_arvalid_o), 518'(1'b1));
            check("araddr_hold", 518'(mem_araddr_o), 518'(ea));
            check("ready_in_ar_wait", 518'(lookup_ready_o), 518'(1'b0));
            @(posedge clk); #1;
        end
        arready = 1'b1;
        @(negedge clk);
        check("arvalid_at_hs", 518'(mem_arvalid_o), 518'(1'b1));
        check("ready_at_hs", 518'(lookup_ready_o), 518'(1'b0));
        @(posedge clk); #1;
        arready = 1'b0;
        @(negedge clk);
        check("arvalid_after_hs", 518'(mem_arvalid_o), 518'(1'b0));
        check("miss_ready_vs_outs", 518'(lookup_ready_o), 518'(outs_m < 4));
        @(posedge clk); #1;
    endtask

    task automatic do_miss(input logic [AW-1:0] a, input int wait_cycles);
        push_miss(a);
        present(1'b0, a, '0);
        outs_m++;
        ar_finish(a, wait_cycles);
    endtask

    task automatic rlast_pulse();
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        outs_m--;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [511:0] l1;
        l1 = mk_line(32'hA5A5_0000);

        // Reset state with a hit pending: nothing may be accepted
        lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_addr = 32'h0000_1028;
        repeat (2) @(negedge clk);
        check("rst_ready", 518'(lookup_ready_o), 518'(1'b0));
        check("rst_arvalid", 518'(mem_arvalid_o), 518'(1'b0));
        check("rst_araddr", 518'(mem_araddr_o), 518'(32'h0));
        check("rst_wren", 518'({hit_flag_fifo_wren_o, hit_data_fifo_wren_o}), 518'(2'b00));
        check("rst_wdata", 518'({hit_flag_fifo_wdata_o, hit_data_fifo_wdata_o}), 518'(0));
        check("rst_ar_const", 518'({mem_arlen_o, mem_arsize_o, mem_arburst_o}), 518'({4'd7, 3'b011, 2'b10}));
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single hit: same-cycle ready and writes, no AR
        push_hit(32'h0000_1028, l1);
        lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_addr = 32'h0000_1028; lookup_line = l1;
        @(negedge clk);
        check("hit_ready", 518'(lookup_ready_o), 518'(1'b1));
        check("hit_offset", 518'(hit_data_fifo_wdata_o[517:512]), 518'(6'h28));
        check("hit_no_ar", 518'(mem_arvalid_o), 518'(1'b0));
        @(posedge clk); #1;
        lookup_valid = 1'b0; lookup_hit = 1'b0;
        @(negedge clk);
        check("hit_no_ar_after", 518'(mem_arvalid_o), 518'(1'b0));
        @(posedge clk); #1;

        // Single miss, arready low for 3 cycles
        do_miss(32'h0000_2014, 3);

        // Outstanding limit: fill to 4
        do_miss(32'h0000_3000, 0);
        do_miss(32'h0000_3108, 0);
        do_miss(32'h0000_31FF, 0);
        lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'h0000_4444;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("limit_ready_low", 518'(lookup_ready_o), 518'(1'b0));
            @(posedge clk); #1;
        end
        // A hit still goes through at the limit
        push_hit(32'h0000_5035, mk_line(32'h1111_2222));
        present(1'b1, 32'h0000_5035, mk_line(32'h1111_2222));
        // Fifth miss waits for one completed burst
        push_miss(32'h0000_4444);
        lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'h0000_4444;
        @(negedge clk);
        check("limit_ready_low2", 518'(lookup_ready_o), 518'(1'b0));
        @(posedge clk); #1;
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        @(negedge clk);
        check("limit_ready_at_rlast", 518'(lookup_ready_o), 518'(1'b0));
        @(posedge clk); #1;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        outs_m--;
        @(negedge clk);
        check("limit_ready_after_rlast", 518'(lookup_ready_o), 518'(1'b1));
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        outs_m++;
        ar_finish(32'h0000_4444, 0);
        repeat (4) rlast_pulse();

        // Backpressure: data afull blocks a hit but not a miss
        data_afull = 1'b1;
        lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_addr = 32'h0000_6000; lookup_line = mk_line(32'h3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("data_afull_hit_blocked", 518'(lookup_ready_o), 518'(1'b0));
            @(posedge clk); #1;
        end
        do_miss(32'h0000_6000, 0);
        data_afull = 1'b0;
        // Flag afull blocks both kinds
        flag_afull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lookup_valid = 1'b1; lookup_hit = (i < 2);
            @(negedge clk);
            check("flag_afull_blocked", 518'(lookup_ready_o), 518'(1'b0));
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0; lookup_hit = 1'b0;
        flag_afull = 1'b0;
        rlast_pulse();

        // Simultaneous miss accept and rlast at outs=2
        do_miss(32'h0000_7000, 0);
        do_miss(32'h0000_7040, 0);
        push_miss(32'h0000_7080);
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        present(1'b0, 32'h0000_7080, '0);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        ar_finish(32'h0000_7080, 1);
        do_miss(32'h0000_70C0, 0);
        do_miss(32'h0000_7100, 0);

        // Async reset in AR_WAIT with outs=4
        rlast_pulse();
        exp_flag_q.push_back(1'b0);
        present(1'b0, 32'h0000_8008, '0);
        @(negedge clk);
        check("pre_rst_arvalid", 518'(mem_arvalid_o), 518'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_arvalid", 518'(mem_arvalid_o), 518'(1'b0));
        check("async_rst_araddr", 518'(mem_araddr_o), 518'(32'h0));
        check("async_rst_ready", 518'(lookup_ready_o), 518'(1'b0));
        outs_m = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_outs_clear", 518'(lookup_ready_o), 518'(1'b1));
        check("post_rst_idle", 518'(mem_arvalid_o), 518'(1'b0));
        @(posedge clk); #1;
        push_hit(32'h0000_9001, mk_line(32'hDEAD_0000));
        present(1'b1, 32'h0000_9001, mk_line(32'hDEAD_0000));
        do_miss(32'h0000_9010, 1);

        repeat (3) @(negedge clk);
        check("flag_q_drained", 518'(exp_flag_q.size()), 518'(0));
        check("data_q_drained", 518'(exp_data_q.size()), 518'(0));
        check("ar_q_drained", 518'(exp_ar_q.size()), 518'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
